demux_4_stream: RTL and testbench
=================================

DEMUX_4_STREAM -- requirements
Module: demux_4_stream

Interface
REQ-001 Parameter: data_length, default 27, width of every data word.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_ready  output  1  block accepts the word this cycle.
REQ-006 in_data  input  data_length  upstream word.
REQ-007 in_sel  input  2  destination lane 0..3; ignored when in_bcast=1.
REQ-008 in_bcast  input  1  copy the word to all four lanes.
REQ-009 out_0, out_1, out_2, out_3  output  data_length each  lane data, registered.
REQ-010 out_valid  output  4  bit i means lane i holds a word.
REQ-011 out_ready  input  4  bit i means the lane i consumer takes the word this cycle.
REQ-012 drop_count  output  16  count of upstream cycles stalled because the target lane was busy.

Function
REQ-013 Each lane i SHALL hold one register, out_i, with a flag, out_valid[i].
REQ-014 Lane i is "free" SHALL mean: out_valid[i]=0, or out_ready[i]=1.
REQ-015 Unicast mode (in_bcast=0): in_ready SHALL equal free[in_sel], combinationally.
REQ-016 Broadcast mode (in_bcast=1): in_ready SHALL equal the AND of free[0..3].
REQ-017 An accept SHALL occur when in_valid=1 and in_ready=1.
REQ-018 Accept latency: the word SHALL appear on out_i, with out_valid[i]=1, on the cycle after the accept.
REQ-019 Unicast accept SHALL write out_{in_sel} only. Other lanes SHALL be unchanged.
REQ-020 Broadcast accept SHALL write in_data to all four lanes in the same cycle.
REQ-021 Lane drained (out_valid[i]=1, out_ready[i]=1) with no new write to lane i: out_valid[i] SHALL clear next cycle.
REQ-022 Simultaneous drain and write on the same lane: out_i SHALL take the new word and out_valid[i] SHALL stay 1. No bubble.
REQ-023 out_i SHALL hold its value while out_valid[i]=1 and out_ready[i]=0.
REQ-024 out_i SHALL NOT change when no write occurs to lane i, including after a drain. Data is don't-care while invalid but SHALL be stable.
REQ-025 out_ready[i] asserted while out_valid[i]=0 SHALL have no effect.
REQ-026 Word order per lane SHALL equal accept order.
REQ-027 No word SHALL be duplicated or lost, except for the intentional four copies in broadcast.
REQ-028 drop_count SHALL increment by 1 on each cycle with in_valid=1 and in_ready=0.
REQ-029 drop_count SHALL saturate at 16'hFFFF. It SHALL NOT wrap.
REQ-030 In_* inputs while in_valid=0 SHALL have no effect.
REQ-031 Upstream SHALL hold in_data, in_sel and in_bcast stable while in_valid=1 and in_ready=0. The block does not check this.

Reset
REQ-032 While rst=1 at a rising edge: out_valid SHALL be 4'b0000, out_0..out_3 SHALL be 0, drop_count SHALL be 0.
REQ-033 While rst=1, in_ready SHALL be 0 and no accept SHALL be recorded.
REQ-034 Reset asserted mid-operation SHALL discard all held words, with no partial broadcast retained.
REQ-035 The first accept SHALL be possible on the first cycle with rst=0.

Verification
REQ-036 Reset check: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, all out_i=0, drop_count=0, in_ready=0.
REQ-037 Unicast fill and drain:
- cycle 0: in_valid=1, in_sel=2, in_data=27'h0000ABC, out_ready=0 -> cycle 1: out_2=27'h0000ABC, out_valid=4'b0100.
- next cycle: second word to lane 2 -> in_ready=0, drop_count=1.
- then raise out_ready[2] -> the second word is accepted that cycle and appears the cycle after, with out_valid[2] held at 1.
REQ-038 Broadcast blocked: lane 1 full with out_ready[1]=0; send broadcast 27'h7FFFFFF.
- in_ready SHALL stay 0 and lanes 0, 2 and 3 SHALL remain invalid.
- release out_ready[1] -> the next cycle shows all four out_i=27'h7FFFFFF and out_valid=4'b1111.
REQ-039 Streaming: in_valid=1 every cycle, in_sel cycling 0,1,2,3, out_ready=4'b1111 -> in_ready=1 every cycle, one word per cycle with 1-cycle latency, drop_count stays 0.
REQ-040 Saturation: hold lane 0 full, out_ready=0, in_valid=1 to lane 0 for 70000 cycles -> drop_count=16'hFFFF, with no wrap.
REQ-041 Mid-stream reset: assert rst=1 for 1 cycle with out_valid=4'b1011 -> the next cycle shows out_valid=0. The held words SHALL never be seen downstream.

Source files
------------

// File: rtl/demux_4_stream.sv
// Four-lane stream demultiplexer: one upstream port feeds four registered
// output lanes, either to a selected lane (unicast) or to all lanes (broadcast).

module demux_4_stream_lane #(
  parameter int DATA_W = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              free
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  // A lane can take a new word when empty or when its word leaves this cycle.
  assign free  = ~valid_q | rd_ready;
  assign data  = data_q;
  assign valid = valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (wr_en) begin
      data_d  = wr_data;
      valid_d = 1'b1;
    end else if (rd_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
endmodule

module demux_4_stream #(
  parameter int data_length = 27
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [data_length-1:0] in_data,
  input  logic [1:0]             in_sel,
  input  logic                   in_bcast,
  output logic [data_length-1:0] out_0,
  output logic [data_length-1:0] out_1,
  output logic [data_length-1:0] out_2,
  output logic [data_length-1:0] out_3,
  output logic [3:0]             out_valid,
  input  logic [3:0]             out_ready,
  output logic [15:0]            drop_count
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]                  lane_free;
  logic [NUM_LANES-1:0]                  wr_en;
  logic [NUM_LANES-1:0][data_length-1:0] lane_data;
  logic                                  accept;
  logic [15:0]                           drop_count_q, drop_count_d;

  // Broadcast waits for every lane so the four copies land together.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) in_ready = in_bcast ? &lane_free : lane_free[in_sel];
  end

  assign accept = in_valid & in_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wr_en[i] = accept & (in_bcast | (in_sel == 2'(i)));
    demux_4_stream_lane #(.DATA_W(data_length)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[i]),
      .wr_data  (in_data),
      .rd_ready (out_ready[i]),
      .data     (lane_data[i]),
      .valid    (out_valid[i]),
      .free     (lane_free[i])
    );
  end

  assign out_0 = lane_data[0];
  assign out_1 = lane_data[1];
  assign out_2 = lane_data[2];
  assign out_3 = lane_data[3];

  always_comb begin
    drop_count_d = drop_count_q;
    if (in_valid && !in_ready && drop_count_q != 16'hFFFF)
      drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_count_q <= '0;
    else     drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
endmodule

// File: tb/tb_demux_4_stream.sv
// Bench for demux_4_stream: directed vector table, hand-written sequences,
// randomized traffic against a queue-based lane model, and counter saturation.

module tb_demux_4_stream;
  localparam int W = 27;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_bcast, in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic [3:0]    out_valid, out_ready;
  logic [15:0]   drop_count;
  logic [W-1:0]  out_0, out_1, out_2, out_3;
  logic [W-1:0]  outs [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_4_stream #(.data_length(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
    .out_valid(out_valid), .out_ready(out_ready), .drop_count(drop_count)
  );

  assign outs[0] = out_0;
  assign outs[1] = out_1;
  assign outs[2] = out_2;
  assign outs[3] = out_3;

  typedef struct packed {
    logic          rst;
    logic          iv;
    logic [1:0]    sel;
    logic          bc;
    logic [W-1:0]  d;
    logic [3:0]    ordy;
    logic          e_irdy;
    logic [3:0]    e_ov;
    logic [1:0]    lane;
    logic [W-1:0]  e_dat;
    logic [15:0]   e_drop;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [1:0] sel,
                       input logic bc, input logic [W-1:0] d, input logic [3:0] ordy);
    rst = r; in_valid = iv; in_sel = sel; in_bcast = bc; in_data = d; out_ready = ordy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: each lane is a one-deep queue; last_w is the last word written.
  logic [W-1:0] lq [4][$];
  logic [W-1:0] last_w [4];
  logic [15:0]  m_drop;

  task automatic model_reset;
    for (int i = 0; i < 4; i++) begin
      lq[i].delete();
      last_w[i] = '0;
    end
    m_drop = '0;
  endtask

  initial begin
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    vecs[0]  = '{H, H, 2'd0, L, 27'h5,       4'b0000, L, 4'b0000, 2'd0, 27'h0,       16'd0};
    vecs[1]  = '{H, H, 2'd0, L, 27'h5,       4'b0000, L, 4'b0000, 2'd3, 27'h0,       16'd0};
    vecs[2]  = '{L, H, 2'd2, L, 27'hABC,     4'b0000, H, 4'b0100, 2'd2, 27'hABC,     16'd0};
    vecs[3]  = '{L, H, 2'd2, L, 27'hDEF,     4'b0000, L, 4'b0100, 2'd2, 27'hABC,     16'd1};
    vecs[4]  = '{L, H, 2'd2, L, 27'hDEF,     4'b0100, H, 4'b0100, 2'd2, 27'hDEF,     16'd1};
    vecs[5]  = '{L, H, 2'd1, L, 27'h111,     4'b0100, H, 4'b0010, 2'd1, 27'h111,     16'd1};
    vecs[6]  = '{L, H, 2'd0, H, 27'h7FFFFFF, 4'b0000, L, 4'b0010, 2'd1, 27'h111,     16'd2};
    vecs[7]  = '{L, H, 2'd0, H, 27'h7FFFFFF, 4'b0000, L, 4'b0010, 2'd0, 27'h0,       16'd3};
    vecs[8]  = '{L, H, 2'd0, H, 27'h7FFFFFF, 4'b0010, H, 4'b1111, 2'd3, 27'h7FFFFFF, 16'd3};
    vecs[9]  = '{L, L, 2'd0, L, 27'h123,     4'b1111, H, 4'b0000, 2'd3, 27'h7FFFFFF, 16'd3};
    vecs[10] = '{L, L, 2'd3, H, 27'h456,     4'b0000, H, 4'b0000, 2'd3, 27'h7FFFFFF, 16'd3};

    drive(1'b1, 1'b1, 2'd0, 1'b0, '0, 4'b0000);

    // Directed table: reset, unicast fill/stall/drain, blocked broadcast, idle inputs.
    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].rst, vecs[v].iv, vecs[v].sel, vecs[v].bc, vecs[v].d, vecs[v].ordy);
      #1;
      chk($sformatf("vec%0d in_ready", v), in_ready, vecs[v].e_irdy);
      tick();
      chk($sformatf("vec%0d out_valid", v), out_valid, vecs[v].e_ov);
      chk($sformatf("vec%0d out_lane%0d", v, vecs[v].lane), outs[vecs[v].lane], vecs[v].e_dat);
      chk($sformatf("vec%0d drop_count", v), drop_count, vecs[v].e_drop);
    end

    // Streaming: one word per cycle round-robin across lanes, never stalling.
    for (int c = 0; c < 8; c++) begin
      logic [1:0]   s;
      logic [W-1:0] d;
      s = 2'(c % 4);
      d = W'(32'h100 + c);
      drive(1'b0, 1'b1, s, 1'b0, d, 4'b1111);
      #1;
      chk("stream in_ready", in_ready, 1'b1);
      tick();
      chk("stream out_valid", out_valid, 4'b0001 << s);
      chk("stream data", outs[s], d);
      chk("stream drop", drop_count, 16'd3);
    end

    // Mid-stream reset with lanes 0, 1, 3 held.
    drive(1'b0, 1'b1, 2'd0, 1'b0, 27'hA0, 4'b0000); tick();
    drive(1'b0, 1'b1, 2'd1, 1'b0, 27'hA1, 4'b0000); tick();
    chk("pre-reset out_valid", out_valid, 4'b1011);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 27'hA2, 4'b0000);
    #1;
    chk("in-reset in_ready", in_ready, 1'b0);
    tick();
    chk("post-reset out_valid", out_valid, 4'b0000);
    for (int i = 0; i < 4; i++) chk($sformatf("post-reset out_%0d", i), outs[i], '0);
    chk("post-reset drop", drop_count, 16'd0);
    drive(1'b0, 1'b1, 2'd2, 1'b0, 27'hB2, 4'b0000);
    #1;
    chk("first-cycle in_ready", in_ready, 1'b1);
    tick();
    chk("first-cycle out_valid", out_valid, 4'b0100);
    chk("first-cycle out_2", out_2, 27'hB2);

    // Randomized traffic against the lane model, with occasional resets.
    drive(1'b1, 1'b0, 2'd0, 1'b0, '0, 4'b0000);
    tick();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      logic          r, iv, bc, e_irdy;
      logic [1:0]    s;
      logic [W-1:0]  d;
      logic [3:0]    ordy, fr, e_ov;
      r    = ($urandom_range(0, 49) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      bc   = ($urandom_range(0, 5) == 0);
      s    = 2'($urandom_range(0, 3));
      d    = W'($urandom);
      ordy = 4'($urandom);
      for (int i = 0; i < 4; i++) fr[i] = (lq[i].size() == 0) || ordy[i];
      e_irdy = r ? 1'b0 : (bc ? &fr : fr[s]);
      drive(r, iv, s, bc, d, ordy);
      #1;
      chk("rand in_ready", in_ready, e_irdy);
      if (r) begin
        model_reset();
      end else begin
        for (int i = 0; i < 4; i++)
          if (ordy[i] && lq[i].size() != 0) void'(lq[i].pop_front());
        if (iv && e_irdy) begin
          for (int i = 0; i < 4; i++)
            if (bc || s == 2'(i)) begin
              lq[i].push_back(d);
              last_w[i] = d;
            end
        end else if (iv && m_drop != 16'hFFFF) begin
          m_drop = m_drop + 16'd1;
        end
      end
      tick();
      for (int i = 0; i < 4; i++) e_ov[i] = (lq[i].size() != 0);
      chk("rand out_valid", out_valid, e_ov);
      for (int i = 0; i < 4; i++) chk($sformatf("rand out_%0d", i), outs[i], last_w[i]);
      chk("rand drop", drop_count, m_drop);
    end

    // Saturation: lane 0 stuck full, upstream keeps pushing to it.
    drive(1'b1, 1'b0, 2'd0, 1'b0, '0, 4'b0000); tick();
    drive(1'b0, 1'b1, 2'd0, 1'b0, 27'hC0, 4'b0000); tick();
    chk("sat lane0 valid", out_valid, 4'b0001);
    for (int n = 1; n <= 70000; n++) begin
      tick();
      if (n == 65534) chk("sat drop 65534", drop_count, 16'hFFFE);
      if (n == 65535) chk("sat drop 65535", drop_count, 16'hFFFF);
    end
    chk("sat drop final", drop_count, 16'hFFFF);
    chk("sat lane0 data", out_0, 27'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
